// File: rtl/i2c_target.sv
// I2C target endpoint: synchronises SCL/SDA, detects START/STOP, matches a 7-bit address,
// ACKs it, delivers written bytes and serves read bytes MSB first.
module i2c_target #(
  parameter logic [6:0] ADDR        = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       start_det,
  output logic       stop_det,
  output logic [2:0] dbg_state
);

  // Fabric handshake: rx_valid and tx_req are single-cycle strobes with no back-pressure.
  // rx_data is stable from the rx_valid cycle until the next byte; tx_data must be valid
  // whenever a byte may load, and tx_req marks the cycle after it was captured.

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_RX       = 3'd3,
    S_RX_ACK   = 3'd4,
    S_TX       = 3'd5,
    S_TX_ACK   = 3'd6,
    S_SKIP     = 3'd7
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_hist_q, scl_hist_d;
  logic                   sda_hist_q, sda_hist_d;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       start_det_q, start_det_d;
  logic       stop_det_q, stop_det_d;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start_cond, stop_cond;
  logic tx_load;

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_hist_q;
  assign scl_fall   = ~scl_s & scl_hist_q;
  // Conditions need SCL high in both samples, so an SDA change racing an SCL edge is ignored.
  assign start_cond = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_cond  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

  // State register: input synchronisers plus all protocol state. Synchronisers reset to
  // the idle bus level so reset release never looks like a bus condition.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_hist_q  <= 1'b1;
      sda_hist_q  <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'd0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_hist_q  <= scl_hist_d;
      sda_hist_q  <= sda_hist_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
    end
  end

  // Next-state logic. START/STOP override any SCL edge seen in the same cycle.
  always_comb begin
    scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d  = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_hist_d  = scl_s;
    sda_hist_d  = sda_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;
    tx_load     = 1'b0;

    if (start_cond) begin
      state_d     = S_ADDR;
      bit_cnt_d   = 4'd0;
      sda_oe_d    = 1'b0;
      start_det_d = 1'b1;
    end else if (stop_cond) begin
      state_d    = S_IDLE;
      sda_oe_d   = 1'b0;
      stop_det_d = 1'b1;
    end else if (scl_rise) begin
      case (state_q)
        S_ADDR: begin
          shift_d = {shift_q[6:0], sda_s};
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            if (shift_q[6:0] == ADDR) begin
              state_d = S_ADDR_ACK;
              rw_d    = sda_s;
            end else begin
              state_d = S_SKIP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_RX: begin
          shift_d = {shift_q[6:0], sda_s};
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d  = 4'd0;
            rx_data_d  = {shift_q[6:0], sda_s};
            rx_valid_d = 1'b1;
            state_d    = S_RX_ACK;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_TX_ACK: begin
          // bit_cnt is already 0 here, so TX loads a fresh byte on the next falling edge.
          state_d = sda_s ? S_SKIP : S_TX;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        S_ADDR_ACK, S_RX_ACK: begin
          // sda_oe itself tells the drive phase from the release phase of the ACK slot.
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            if ((state_q == S_ADDR_ACK) && rw_q) begin
              state_d = S_TX;
              tx_load = 1'b1;
            end else begin
              state_d = S_RX;
            end
          end
        end
        S_TX: begin
          if (bit_cnt_q == 4'd0) begin
            tx_load = 1'b1;
          end else if (bit_cnt_q == 4'd8) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = S_TX_ACK;
          end else begin
            sda_oe_d  = ~shift_q[7];
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
      // bit_cnt counts bits already placed on the line for the current TX byte.
      if (tx_load) begin
        shift_d   = {tx_data[6:0], 1'b0};
        sda_oe_d  = ~tx_data[7];
        tx_req_d  = 1'b1;
        bit_cnt_d = 4'd1;
      end
    end
  end

  // Output logic
  always_comb begin
    sda_oe    = sda_oe_q;
    busy      = (state_q != S_IDLE) && (state_q != S_SKIP);
    rx_data   = rx_data_q;
    rx_valid  = rx_valid_q;
    tx_req    = tx_req_q;
    start_det = start_det_q;
    stop_det  = stop_det_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-level I2C host drives directed and random transactions;
// a transaction model predicts ACKs, read bytes and fabric strobes, checked by a monitor.
module tb_i2c_target;

  localparam int         T       = 6;     // sys_clk cycles per quarter SCL period
  localparam logic [6:0] ADDR    = 7'h1A;
  localparam logic [2:0] ST_IDLE = 3'd0;

  logic       sys_clk;
  logic       rst_n;
  logic       host_scl;
  logic       host_sda;
  logic       sda_line;
  logic       sda_oe;
  logic       busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       start_det;
  logic       stop_det;
  logic [2:0] dbg_state;

  int vectors    = 0;
  int miscompares = 0;
  int cnt_start  = 0;
  int cnt_stop   = 0;
  int cnt_txreq  = 0;
  int exp_start  = 0;
  int exp_stop   = 0;
  int exp_txreq  = 0;
  bit bus_idle   = 1'b1;

  logic [7:0] exp_q[$];
  logic [7:0] wdat[4];
  logic [7:0] tdat[4];

  assign sda_line = host_sda & ~sda_oe;

  i2c_target #(.ADDR(ADDR), .SYNC_STAGES(2)) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .scl_in    (host_scl),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .start_det (start_det),
    .stop_det  (stop_det),
    .dbg_state (dbg_state)
  );

  // Clock
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected written byte whenever the DUT strobes rx_valid.
  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          check("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
        end else begin
          check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
      end
      if (start_det) cnt_start++;
      if (stop_det)  cnt_stop++;
      if (tx_req)    cnt_txreq++;
    end
  end

  // Host driver tasks; all changes happen on the falling sys_clk edge.
  task automatic half();
    repeat (T) @(negedge sys_clk);
  endtask

  task automatic send_bit(input logic b, output logic seen);
    half(); host_sda = b;
    half(); host_scl = 1'b1;
    half(); seen = sda_line;
    half(); host_scl = 1'b0;
  endtask

  task automatic do_start();
    if (bus_idle) begin
      host_sda = 1'b0;
      half(); host_scl = 1'b0;
    end else begin
      half(); host_sda = 1'b1;
      half(); host_scl = 1'b1;
      half(); host_sda = 1'b0;
      half(); host_scl = 1'b0;
    end
    bus_idle = 1'b0;
  endtask

  task automatic do_stop();
    half(); host_sda = 1'b0;
    half(); host_scl = 1'b1;
    half(); host_sda = 1'b1;
    half();
    bus_idle = 1'b1;
  endtask

  task automatic write_byte(input logic [7:0] b, input bit exp_ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    check("ack", {31'd0, s}, {31'd0, ~exp_ack});
  endtask

  task automatic read_byte(input logic [7:0] exp, input bit host_ack, input logic [7:0] next_tx);
    logic [7:0] got;
    logic       s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      got[i] = s;
    end
    check("rd_byte", {24'd0, got}, {24'd0, exp});
    half(); host_sda = ~host_ack; tx_data = next_tx;
    half(); host_scl = 1'b1;
    half();
    half(); host_scl = 1'b0;
    if (!host_ack) begin
      half();
      check("oe_after_nack", {31'd0, sda_oe}, 32'd0);
    end
  endtask

  // One transaction: address byte, n data bytes, optional partial byte, STOP or open end.
  task automatic run_txn(input logic [7:0] ab, input int n, input int pbits, input bit stop);
    bit   match;
    bit   rd;
    logic s;
    match = (ab[7:1] == ADDR);
    rd    = match && ab[0];
    tx_data = tdat[0];
    do_start();
    exp_start++;
    write_byte(ab, match);
    for (int k = 0; k < n; k++) begin
      if (rd) begin
        read_byte(tdat[k], (k < n - 1), (k + 1 < n) ? tdat[k+1] : 8'h00);
      end else begin
        if (match) exp_q.push_back(wdat[k]);
        write_byte(wdat[k], match);
        if (!match) check("busy_skip", {31'd0, busy}, 32'd0);
      end
    end
    if (rd) exp_txreq += n;
    if (!rd) begin
      for (int i = 0; i < pbits; i++) send_bit(1'($urandom_range(0, 1)), s);
    end
    if (stop) begin
      do_stop();
      exp_stop++;
    end
    repeat (4) @(negedge sys_clk);
    check("start_cnt", cnt_start, exp_start);
    check("stop_cnt", cnt_stop, exp_stop);
    check("txreq_cnt", cnt_txreq, exp_txreq);
    check("rx_pending", exp_q.size(), 32'd0);
    if (stop) check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int         n;
    int         pb;
    logic [7:0] ab;
    logic       s;
    rst_n    = 1'b0;
    host_scl = 1'b1;
    host_sda = 1'b1;
    tx_data  = 8'h00;
    repeat (4) @(negedge sys_clk);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_strobes", {28'd0, rx_valid, tx_req, start_det, stop_det}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);

    // Write 0x34, 0xA5, STOP
    wdat[0] = 8'hA5;
    run_txn(8'h34, 1, 0, 1'b1);
    // Foreign address 0x1B
    wdat[0] = 8'h77;
    run_txn(8'h36, 1, 0, 1'b1);
    // Read 0x3C (host ACK), 0xC3 (host NACK)
    tdat[0] = 8'h3C; tdat[1] = 8'hC3;
    run_txn(8'h35, 2, 0, 1'b1);
    // Repeated START after 3 data bits, then full write of 0x5A
    run_txn(8'h34, 0, 3, 1'b0);
    wdat[0] = 8'h5A;
    run_txn(8'h34, 1, 0, 1'b1);
    check("rx_data_hold", {24'd0, rx_data}, 32'h5A);

    // Reset while the address ACK is being driven
    do_start();
    exp_start++;
    for (int i = 7; i >= 0; i--) send_bit(ab_bit(8'h34, i), s);
    for (int w = 0; w < 20 && !sda_oe; w++) @(negedge sys_clk);
    check("ack_driven", {31'd0, sda_oe}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check("async_release", {31'd0, sda_oe}, 32'd0);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("post_rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    do_stop();
    exp_stop++;

    // STOP after 5 data bits, then write 0x11
    run_txn(8'h34, 0, 5, 1'b1);
    check("partial_stop_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    wdat[0] = 8'h11;
    run_txn(8'h34, 1, 0, 1'b1);
    check("rx_data_after_abort", {24'd0, rx_data}, 32'h11);

    // Random transactions
    for (int t = 0; t < 36; t++) begin
      if ($urandom_range(0, 2) != 0) ab = {ADDR, 1'($urandom_range(0, 1))};
      else ab = 8'($urandom_range(0, 255));
      n = $urandom_range(0, 3);
      if ((ab[7:1] == ADDR) && ab[0] && (n == 0)) n = 1;
      pb = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 7) : 0;
      for (int k = 0; k < 4; k++) begin
        wdat[k] = 8'($urandom_range(0, 255));
        tdat[k] = 8'($urandom_range(0, 255));
      end
      run_txn(ab, n, pb, ($urandom_range(0, 3) != 0) || (t == 35));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  function automatic logic ab_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction

endmodule
